// File: rtl/ax_bx_pkg.sv
// Shared opcode, instruction-field and state definitions for the AX/BX
// micro-sequencer and its ALU.
package ax_bx_pkg;

  localparam int unsigned INSTR_W = 7;

  localparam int unsigned KOP_MSB = 6;
  localparam int unsigned KOP_LSB = 3;
  localparam int unsigned REG_BIT = 2;
  localparam int unsigned IMM_MSB = 1;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0111;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

endpackage

// File: rtl/ax_bx_alu.sv
// Combinational AX/BX datapath: computes the next AX/BX for one decoded
// instruction and flags opcodes outside the defined set.
module ax_bx_alu
  import ax_bx_pkg::*;
#(
  parameter int unsigned DATA_W = 2
) (
  input  logic [3:0]        kop,
  input  logic              rsel,
  input  logic [1:0]        imm,
  input  logic [DATA_W-1:0] ax,
  input  logic [DATA_W-1:0] bx,
  output logic [DATA_W-1:0] ax_nxt,
  output logic [DATA_W-1:0] bx_nxt,
  output logic              illegal
);

  logic [DATA_W-1:0] dst;
  logic [DATA_W-1:0] oth;
  logic [DATA_W-1:0] imm_x;
  logic [DATA_W-1:0] res;

  always_comb begin
    dst   = rsel ? bx : ax;
    oth   = rsel ? ax : bx;
    imm_x = DATA_W'(imm);
  end

  // NOP, HALT and illegal opcodes rewrite the destination with itself
  always_comb begin
    res     = dst;
    illegal = 1'b0;
    case (kop)
      OP_NOP:  res = dst;
      OP_LDI:  res = imm_x;
      OP_MOV:  res = oth;
      OP_OR:   res = ax | bx;
      OP_XOR:  res = ax ^ bx;
      OP_NOT:  res = ~dst;
      OP_AND:  res = ax & bx;
      OP_HALT: res = dst;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    ax_nxt = rsel ? ax  : res;
    bx_nxt = rsel ? res : bx;
  end

endmodule

// File: rtl/ax_bx_sequencer.sv
// Micro-sequencer: runs a host-loaded program from internal memory on the
// AX/BX datapath, two cycles (fetch, execute) per instruction.
module ax_bx_sequencer
  import ax_bx_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W       = 4,
  parameter int unsigned DATA_W     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [PC_W-1:0]    pc,
  output logic [DATA_W-1:0]  ax,
  output logic [DATA_W-1:0]  bx
);

  logic [1:0]         state;
  logic [INSTR_W-1:0] ir;
  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  logic [3:0]         kop;
  logic               rsel;
  logic [1:0]         imm;
  logic [DATA_W-1:0]  ax_nxt;
  logic [DATA_W-1:0]  bx_nxt;
  logic               illegal;

  always_comb begin
    kop  = ir[KOP_MSB:KOP_LSB];
    rsel = ir[REG_BIT];
    imm  = ir[IMM_MSB:IMM_LSB];
    busy = (state != ST_IDLE);
  end

  ax_bx_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .kop     (kop),
    .rsel    (rsel),
    .imm     (imm),
    .ax      (ax),
    .bx      (bx),
    .ax_nxt  (ax_nxt),
    .bx_nxt  (bx_nxt),
    .illegal (illegal)
  );

  // Program store is cleared by reset, so a reset wipes any loaded program
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PROG_DEPTH; i++) mem[i] <= '0;
    end else if (prog_we && state == ST_IDLE) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
      ax    <= '0;
      bx    <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            pc    <= '0;
            err   <= 1'b0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir    <= mem[pc];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          ax <= ax_nxt;
          bx <= bx_nxt;
          if (illegal) err <= 1'b1;
          if (kop == OP_HALT) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end else if (pc == PC_W'(PROG_DEPTH - 1)) begin
            pc    <= '0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ax_bx_sequencer.sv
// Directed bench for ax_bx_sequencer: programs, runs and checks register
// results, done latency, err behaviour, busy lockout and mid-run reset.
module tb_ax_bx_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [6:0] prog_wdata;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] pc;
  logic [1:0] ax;
  logic [1:0] bx;

  int tests;
  int fails;
  int n;
  logic [1:0] h_ax  [0:127];
  logic [1:0] h_bx  [0:127];
  logic       h_err [0:127];
  logic       h_busy[0:127];
  logic       seen_done;

  localparam logic [3:0] K_NOP  = 4'b0000;
  localparam logic [3:0] K_LDI  = 4'b0001;
  localparam logic [3:0] K_MOV  = 4'b0010;
  localparam logic [3:0] K_OR   = 4'b0011;
  localparam logic [3:0] K_XOR  = 4'b0100;
  localparam logic [3:0] K_NOT  = 4'b0101;
  localparam logic [3:0] K_AND  = 4'b0111;
  localparam logic [3:0] K_HALT = 4'b1111;

  ax_bx_sequencer #(
    .PROG_DEPTH (16),
    .PC_W       (4),
    .DATA_W     (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .pc         (pc),
    .ax         (ax),
    .bx         (bx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ins(input logic [3:0] k, input logic r, input logic [1:0] i);
    return {k, r, i};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [6:0] d);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  // Start a run, record per-cycle state after each edge; at cycle inj (if
  // nonzero) pulse start plus a HALT write to address 0 while busy.
  task automatic run(input string tag, input int exp_lat, input int inj);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      start   = 1'b0;
      prog_we = 1'b0;
      n++;
      h_ax[n]   = ax;
      h_bx[n]   = bx;
      h_err[n]  = err;
      h_busy[n] = busy;
      if (done || n >= 100) break;
      if (n == inj) begin
        start      = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = 4'd0;
        prog_wdata = ins(K_HALT, 1'b0, 2'd0);
      end
    end
    check({tag, "_latency"}, n, exp_lat);
    @(posedge clk);
    #1 check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_wdata = '0;

    // Reset values
    #12;
    check("rst_ax", {30'd0, ax}, 32'd0);
    check("rst_bx", {30'd0, bx}, 32'd0);
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_busy", {31'd0, busy}, 32'd0);

    // Empty program: 16 NOPs, wrap ends the run
    run("empty", 32, 0);
    check("empty_ax", {30'd0, ax}, 32'd0);
    check("empty_bx", {30'd0, bx}, 32'd0);
    check("empty_pc", {28'd0, pc}, 32'd0);
    check("empty_busy1", {31'd0, h_busy[1]}, 32'd1);

    // LDI A,3; LDI B,2; AND A; HALT
    write_word(4'd0, ins(K_LDI, 1'b0, 2'd3));
    write_word(4'd1, ins(K_LDI, 1'b1, 2'd2));
    write_word(4'd2, ins(K_AND, 1'b0, 2'd0));
    write_word(4'd3, ins(K_HALT, 1'b0, 2'd0));
    run("and", 8, 0);
    check("and_ax", {30'd0, ax}, 32'd2);
    check("and_bx", {30'd0, bx}, 32'd2);
    check("and_err", {31'd0, err}, 32'd0);
    check("and_ldi_a", {30'd0, h_ax[2]}, 32'd3);

    // LDI A,1; LDI B,3; AND B; NOT A; OR A; HALT
    write_word(4'd0, ins(K_LDI, 1'b0, 2'd1));
    write_word(4'd1, ins(K_LDI, 1'b1, 2'd3));
    write_word(4'd2, ins(K_AND, 1'b1, 2'd0));
    write_word(4'd3, ins(K_NOT, 1'b0, 2'd0));
    write_word(4'd4, ins(K_OR, 1'b0, 2'd0));
    write_word(4'd5, ins(K_HALT, 1'b0, 2'd0));
    run("chain", 12, 0);
    check("chain_andb_bx", {30'd0, h_bx[6]}, 32'd1);
    check("chain_andb_ax", {30'd0, h_ax[6]}, 32'd1);
    check("chain_not_ax", {30'd0, h_ax[8]}, 32'd2);
    check("chain_or_ax", {30'd0, h_ax[10]}, 32'd3);
    check("chain_ax", {30'd0, ax}, 32'd3);
    check("chain_bx", {30'd0, bx}, 32'd1);

    // Illegal opcode sets sticky err; next start clears it
    write_word(4'd0, ins(K_LDI, 1'b0, 2'd2));
    write_word(4'd1, ins(4'b1010, 1'b0, 2'd1));
    write_word(4'd2, ins(K_HALT, 1'b0, 2'd0));
    run("ill", 6, 0);
    check("ill_err", {31'd0, err}, 32'd1);
    check("ill_ax", {30'd0, ax}, 32'd2);
    repeat (3) @(posedge clk);
    #1 check("ill_err_sticky", {31'd0, err}, 32'd1);
    run("ill2", 6, 0);
    check("ill2_err_cleared", {31'd0, h_err[1]}, 32'd0);
    check("ill2_err", {31'd0, err}, 32'd1);

    // start and prog_we while busy are ignored
    write_word(4'd0, ins(K_LDI, 1'b0, 2'd1));
    write_word(4'd1, ins(K_LDI, 1'b1, 2'd2));
    write_word(4'd2, ins(K_XOR, 1'b0, 2'd0));
    write_word(4'd3, ins(K_MOV, 1'b1, 2'd0));
    write_word(4'd4, ins(K_HALT, 1'b0, 2'd0));
    run("busy", 10, 2);
    check("busy_xor_ax", {30'd0, h_ax[6]}, 32'd3);
    check("busy_ax", {30'd0, ax}, 32'd3);
    check("busy_bx", {30'd0, bx}, 32'd3);
    run("rerun", 10, 0);
    check("rerun_ldi_ax", {30'd0, h_ax[2]}, 32'd1);
    check("rerun_ax", {30'd0, ax}, 32'd3);

    // Reset during EXEC of LDI B,3
    write_word(4'd0, ins(K_LDI, 1'b0, 2'd1));
    write_word(4'd1, ins(K_LDI, 1'b1, 2'd3));
    write_word(4'd2, ins(K_HALT, 1'b0, 2'd0));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_pre_ax", {30'd0, ax}, 32'd1);
    check("mid_pre_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_ax", {30'd0, ax}, 32'd0);
    check("mid_bx", {30'd0, bx}, 32'd0);
    check("mid_pc", {28'd0, pc}, 32'd0);
    check("mid_busy", {31'd0, busy}, 32'd0);
    seen_done = done;
    repeat (3) begin
      @(posedge clk);
      #1 seen_done = seen_done | done;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 seen_done = seen_done | done;
    end
    check("mid_no_done", {31'd0, seen_done}, 32'd0);
    run("cleared", 32, 0);
    check("cleared_ax", {30'd0, ax}, 32'd0);
    check("cleared_bx", {30'd0, bx}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
